uart_rx: RTL

Serial-to-parallel UART receiver, 8N1, LSB first, line idles high. It sits directly upstream of the instruction-fetch stage and feeds it rx_do and rx_data. The fetch stage assembles the instruction-high byte and then the instruction-low byte from successive rx_do pulses. It also feeds the data read/write path, which shares the same serial link.

---
 rtl/uart_pkg.sv | 16 +
 rtl/rx_sync.sv | 25 ++
 rtl/uart_rx.sv | 129 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: FSM state encodings, frame geometry and link command bytes.
package uart_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 87;

  // Command byte recognised by the transmit and fetch stages.
  localparam logic [7:0] FLAG_FETCH = 8'h03;

endpackage

// File: rtl/rx_sync.sv
// Multi-flop synchroniser for the asynchronous rx line; resets to the idle (high) level.
module rx_sync
  import uart_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rx_i,
  output logic rxs_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
    end
  end

  assign rxs_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first: mid-bit sampling of the synchronised line, one-cycle
// rx_do / frame_err pulses, and a BREAK state that waits out a held-low line.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic                 rx_do,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  logic                 rxs;
  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 do_q, do_d;
  logic                 err_q, err_d;

  rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rx_sync (
    .clk_i (clk),
    .rst_ni(reset),
    .rx_i  (rx),
    .rxs_o (rxs)
  );

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    do_d    = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d = START;
          baud_d  = '0;
        end
      end
      START: begin
        if (baud_q == HALF_M1) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = rxs ? IDLE : DATA;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (baud_q == FULL_M1) begin
          baud_d         = '0;
          shift_d[bit_q] = rxs;
          if (bit_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (baud_q == FULL_M1) begin
          baud_d = '0;
          if (rxs) begin
            data_d  = shift_q;
            do_d    = 1'b1;
            state_d = IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = BREAK;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      BREAK: begin
        // A held-low line must go idle before a new start bit can be recognised.
        if (rxs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      do_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      do_q    <= do_d;
      err_q   <= err_d;
    end
  end

  assign rx_do     = do_q;
  assign frame_err = err_q;
  assign rx_data   = data_q;
  assign busy      = (state_q != IDLE);

endmodule
